// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: issue-side controller for the 8-bit combinational ALU.
// Each instruction takes four cycles (IDLE -> READ -> EXEC -> WB). The
// 8x8 register file supplies the operands, and the captured ALU result
// is written back through a one-cycle wb_valid pulse.
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic        instr_imm_en,
    input  logic [7:0]  instr_imm,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    output logic [2:0]  alu_shift,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    output logic        wb_valid,
    output logic [2:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic        flag_zero,
    output logic        flag_neg,
    output logic        flag_carry,
    output logic        flag_ovf,
    output logic        div_err,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      state_reg;

    // Latched instruction fields
    logic [3:0]  op_reg;
    logic [2:0]  rd_reg;
    logic [2:0]  rs_reg;
    logic [2:0]  rt_reg;
    logic [2:0]  sh_reg;
    logic        imm_en_reg;
    logic [7:0]  imm_reg;

    // Registered outputs
    logic [7:0]  alu_a_reg;
    logic [7:0]  alu_b_reg;
    logic [3:0]  alu_sel_reg;
    logic [2:0]  alu_shift_reg;
    logic        wb_valid_reg;
    logic [2:0]  wb_addr_reg;
    logic [7:0]  wb_data_reg;
    logic        flag_zero_reg;
    logic        flag_neg_reg;
    logic        flag_carry_reg;
    logic        flag_ovf_reg;
    logic        div_err_reg;

    // Register file. R0 is never written, and every read port forces it to 0.
    logic [7:0]  rf_reg [8];

    logic [7:0]  rs_val;
    logic [7:0]  rt_val;
    logic        div_zero;

    assign instr_ready = (state_reg == S_IDLE);

    assign rs_val   = (rs_reg == 3'd0)   ? 8'd0 : rf_reg[rs_reg];
    assign rt_val   = (rt_reg == 3'd0)   ? 8'd0 : rf_reg[rt_reg];
    assign dbg_data = (dbg_addr == 3'd0) ? 8'd0 : rf_reg[dbg_addr];

    // Divide by zero is detected on the operands that the ALU is currently seeing.
    assign div_zero = (alu_sel_reg == OP_DIV) && (alu_b_reg == 8'd0);

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_sel    = alu_sel_reg;
    assign alu_shift  = alu_shift_reg;
    assign wb_valid   = wb_valid_reg;
    assign wb_addr    = wb_addr_reg;
    assign wb_data    = wb_data_reg;
    assign flag_zero  = flag_zero_reg;
    assign flag_neg   = flag_neg_reg;
    assign flag_carry = flag_carry_reg;
    assign flag_ovf   = flag_ovf_reg;
    assign div_err    = div_err_reg;

    // Register file write. This happens on the edge that leaves WB, so dbg_data shows the new value one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_reg[i] <= 8'd0;
            end
        end else if (state_reg == S_WB && wb_valid_reg && wb_addr_reg != 3'd0) begin
            rf_reg[wb_addr_reg] <= wb_data_reg;
        end
    end

    // Main sequencer: accept, drive the operands, capture the result and flags, then write back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            op_reg         <= 4'd0;
            rd_reg         <= 3'd0;
            rs_reg         <= 3'd0;
            rt_reg         <= 3'd0;
            sh_reg         <= 3'd0;
            imm_en_reg     <= 1'b0;
            imm_reg        <= 8'd0;
            alu_a_reg      <= 8'd0;
            alu_b_reg      <= 8'd0;
            alu_sel_reg    <= 4'd0;
            alu_shift_reg  <= 3'd0;
            wb_valid_reg   <= 1'b0;
            wb_addr_reg    <= 3'd0;
            wb_data_reg    <= 8'd0;
            flag_zero_reg  <= 1'b0;
            flag_neg_reg   <= 1'b0;
            flag_carry_reg <= 1'b0;
            flag_ovf_reg   <= 1'b0;
            div_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_reg     <= instr[15:12];
                        rd_reg     <= instr[11:9];
                        rs_reg     <= instr[8:6];
                        rt_reg     <= instr[5:3];
                        sh_reg     <= instr[2:0];
                        imm_en_reg <= instr_imm_en;
                        imm_reg    <= instr_imm;
                        state_reg  <= S_READ;
                    end
                end
                S_READ: begin
                    alu_a_reg     <= rs_val;
                    alu_b_reg     <= imm_en_reg ? imm_reg : rt_val;
                    alu_sel_reg   <= op_reg;
                    alu_shift_reg <= sh_reg;
                    state_reg     <= S_EXEC;
                end
                S_EXEC: begin
                    if (div_zero) begin
                        // Keep the flags, throw the result away, and latch the error until reset.
                        div_err_reg <= 1'b1;
                    end else begin
                        flag_zero_reg  <= (alu_out == 8'd0);
                        flag_neg_reg   <= alu_out[7];
                        flag_carry_reg <= alu_carry;
                        flag_ovf_reg   <= alu_overflow;
                        if (rd_reg != 3'd0) begin
                            wb_valid_reg <= 1'b1;
                            wb_addr_reg  <= rd_reg;
                            wb_data_reg  <= alu_out;
                        end
                    end
                    state_reg <= S_WB;
                end
                S_WB: begin
                    wb_valid_reg <= 1'b0;
                    state_reg    <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execution controller that drives the 8-bit `ALU` from the issuing side. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 8×8 register file. It presents those operands, the opcode and the shift field to the ALU, then captures the result and flags and writes the result back. It sits between instruction fetch/decode and the combinational ALU in the MCU datapath.

## Interface
- No parameters; widths fixed: data 8, opcode 4, register address 3, shift 3.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: controller can accept an instruction.
- `instr` in 16: [15:12] alu_sel, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] shift.
- `instr_imm_en` in 1: when 1, operand B = `instr_imm` instead of R[rt].
- `instr_imm` in 8: immediate operand.
- `alu_a`, `alu_b` out 8: registered operands to the ALU.
- `alu_sel` out 4: registered ALU_Sel.
- `alu_shift` out 3: registered shift field, passed through.
- `alu_out` in 8: ALU result.
- `alu_carry`, `alu_overflow` in 1: ALU flags.
- `wb_valid` out 1: one-cycle pulse on register write-back.
- `wb_addr` out 3, `wb_data` out 8: write-back target and value.
- `flag_zero`, `flag_neg`, `flag_carry`, `flag_ovf` out 1: status register.
- `div_err` out 1: sticky divide-by-zero error. Cleared only by `rst`.
- `dbg_addr` in 3, `dbg_data` out 8: combinational register-file read port.

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE. No other transitions except reset to IDLE.
- IDLE:
  - `instr_ready`=1 only in IDLE.
  - On `instr_valid & instr_ready`, latch the instr fields, imm_en and imm; go to READ.
- READ:
  - `alu_a` ← R[rs]; `alu_b` ← imm_en ? imm : R[rt].
  - `alu_sel` ← instr[15:12]; `alu_shift` ← instr[2:0]. Go to EXEC.
- EXEC:
  - Capture `alu_out` into the result register.
  - flag_zero ← (alu_out==0); flag_neg ← alu_out[7].
  - flag_carry ← alu_carry; flag_ovf ← alu_overflow. Go to WB.
  - If alu_sel=4'b0011 and alu_b=0: flags unchanged, result discarded, `div_err` set, write-back suppressed.
- WB:
  - If not suppressed and rd≠0: R[rd] ← result, `wb_valid`=1, `wb_addr`=rd, `wb_data`=result.
  - If rd=0: no write, `wb_valid`=0. Flags are still updated.
  - Go to IDLE.
- R0:
  - Always reads 0, including on `dbg_data`. Writes to R0 are discarded.
- Operand/result arithmetic:
  - Operands are unsigned 8-bit.
  - Result is exactly `alu_out` (ALU truncates to 8 bits); no widening in the controller.
  - Comparison ops (1110, 1111) write 0 or 1 like any other op.
- `alu_a`/`alu_b`/`alu_sel`/`alu_shift` hold their values outside READ until the next READ.
- `dbg_data` reflects register writes from the cycle after WB.

## Timing
- Accept at edge N (IDLE). READ updates ALU inputs at N+1. EXEC captures at N+2. WB writes at N+3; `wb_valid` is high during the cycle following edge N+2.
- `instr_ready` rises again in the cycle after WB. Throughput is one instruction per 4 cycles.
- Back-to-back dependent instructions need no forwarding: R[rd] is written before the next READ.
- Reset values:
  - All registers R0–R7 = 0.
  - `alu_a`, `alu_b`, `wb_data` = 0; `alu_sel`, `alu_shift`, `wb_addr` = 0.
  - `wb_valid`, all flags and `div_err` = 0.
  - State = IDLE, so `instr_ready`=1 in the first cycle after reset release.
- Reset in any state:
  - Abort the instruction; the next edge is IDLE.
  - No `wb_valid`, no register write.
- `instr_valid` held high while `instr_ready`=0 is ignored. The instruction must be held until accepted.

## Test plan
- Reset, then ADD r1,r0,#5 (imm_en): `wb_valid` pulse 3 cycles after accept, wb_addr=1, wb_data=5, `dbg_data`(1)=5, flag_zero=0.
- Load r1=200, r2=100, then ADD r3,r1,r2: wb_data=44 (0x2C), flag_carry reflects ALU carry=1, flag_neg=0. SUB r4,r2,r1: wb_data=156, flag_neg=1.
- DIV r5,r1,#0: `div_err`=1, no `wb_valid`, R5 unchanged, flags unchanged. A following DIV r5,r1,#10 writes 20; `div_err` stays 1.
- XOR r0,r1,r1: no write, `dbg_data`(0)=0, flag_zero=1. EQ (1111) r6,r1,r1 writes 1.
- `instr_valid` held high continuously for 3 instructions: `instr_ready` toggles 1,0,0,0; exactly 3 `wb_valid` pulses spaced 4 cycles apart.
- Assert `rst` during EXEC of ADD r7,#9: no `wb_valid`, R7=0, all outputs at reset values, `instr_ready`=1 in the cycle after reset deasserts.
